// File: rtl/ram_march_bist.sv
// March C- self-test initiator for a single-port RAM with one-cycle read latency.
// Reports pass/fail, the first failing word and a saturating miscompare count.
module ram_march_bist #(
   parameter int DATA_WIDTH      = 32,
   parameter int BYTE_ADDR_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [DATA_WIDTH-1:0]      background,
   output logic                       ram_en,
   output logic                       ram_wen,
   output logic [BYTE_ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]      ram_din,
   input  logic [DATA_WIDTH-1:0]      ram_dout,
   output logic                       busy,
   output logic                       done,
   output logic                       fail,
   output logic [15:0]                err_count,
   output logic [BYTE_ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0]      fail_data,
   output logic [DATA_WIDTH-1:0]      fail_expected
);

   localparam logic [BYTE_ADDR_WIDTH-1:0] LAST = '1;
   localparam logic [BYTE_ADDR_WIDTH-1:0] FIRST = '0;

   typedef enum logic [3:0] {
      S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH, S_DONE
   } state_t;

   state_t                     r_state, w_state;
   logic                       r_en, w_en;
   logic                       r_wen, w_wen;
   logic [BYTE_ADDR_WIDTH-1:0] r_addr, w_addr;
   logic [DATA_WIDTH-1:0]      r_din, w_din;
   logic [DATA_WIDTH-1:0]      r_exp, w_exp;
   logic [DATA_WIDTH-1:0]      r_bg, w_bg;
   logic                       r_busy, r_done;
   logic                       w_go;
   logic                       w_inv_rd, w_inv_wr;

   logic                       r_chk_valid;
   logic [BYTE_ADDR_WIDTH-1:0] r_chk_addr;
   logic [DATA_WIDTH-1:0]      r_chk_exp;
   logic                       r_fail;
   logic [15:0]                r_err;
   logic [BYTE_ADDR_WIDTH-1:0] r_fail_addr;
   logic [DATA_WIDTH-1:0]      r_fail_data;
   logic [DATA_WIDTH-1:0]      r_fail_exp;
   logic                       w_miss;

   // Next-op generator: the registers hold the op on the bus this cycle
   always_comb begin
      w_state  = r_state;
      w_addr   = '0;
      w_en     = 1'b0;
      w_wen    = 1'b0;
      w_din    = '0;
      w_exp    = '0;
      w_go     = 1'b0;
      w_bg     = r_bg;
      w_inv_rd = 1'b0;
      w_inv_wr = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_go    = 1'b1;
               w_bg    = background;
               w_state = S_M0;
               w_en    = 1'b1;
               w_wen   = 1'b1;
            end
         end
         S_M0: begin
            w_en = 1'b1;
            if (r_addr == LAST) begin
               w_state = S_M1;
            end else begin
               w_addr = r_addr + 1'b1;
               w_wen  = 1'b1;
            end
         end
         S_M1, S_M2, S_M3, S_M4: begin
            w_en = 1'b1;
            if (!r_wen) begin
               w_wen  = 1'b1;
               w_addr = r_addr;
            end else begin
               unique case (r_state)
                  S_M1: begin
                     if (r_addr == LAST) begin
                        w_state = S_M2;
                        w_addr  = FIRST;
                     end else w_addr = r_addr + 1'b1;
                  end
                  S_M2: begin
                     if (r_addr == LAST) begin
                        w_state = S_M3;
                        w_addr  = LAST;
                     end else w_addr = r_addr + 1'b1;
                  end
                  S_M3: begin
                     if (r_addr == FIRST) begin
                        w_state = S_M4;
                        w_addr  = LAST;
                     end else w_addr = r_addr - 1'b1;
                  end
                  default: begin
                     if (r_addr == FIRST) begin
                        w_state = S_M5;
                        w_addr  = FIRST;
                     end else w_addr = r_addr - 1'b1;
                  end
               endcase
            end
         end
         S_M5: begin
            if (r_addr == LAST) begin
               w_state = S_FLUSH;
            end else begin
               w_en   = 1'b1;
               w_addr = r_addr + 1'b1;
            end
         end
         S_FLUSH: w_state = S_DONE;
      endcase

      w_inv_rd = (w_state == S_M2) || (w_state == S_M4);
      w_inv_wr = (w_state == S_M1) || (w_state == S_M3);
      if (w_en) begin
         if (w_wen) w_din = w_inv_wr ? ~w_bg : w_bg;
         else       w_exp = w_inv_rd ? ~w_bg : w_bg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_en    <= 1'b0;
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_din   <= '0;
         r_exp   <= '0;
         r_bg    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_en    <= w_en;
         r_wen   <= w_wen;
         r_addr  <= w_addr;
         r_din   <= w_din;
         r_exp   <= w_exp;
         r_bg    <= w_bg;
         r_busy  <= (w_state != S_IDLE) && (w_state != S_DONE);
         r_done  <= (w_state == S_DONE);
      end
   end

   assign w_miss = r_chk_valid && (ram_dout != r_chk_exp);

   // Read data returns one cycle after issue, so the compare trails the op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chk_valid <= 1'b0;
         r_chk_addr  <= '0;
         r_chk_exp   <= '0;
         r_fail      <= 1'b0;
         r_err       <= '0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
         r_fail_exp  <= '0;
      end else if (w_go) begin
         r_chk_valid <= 1'b0;
         r_chk_addr  <= '0;
         r_chk_exp   <= '0;
         r_fail      <= 1'b0;
         r_err       <= '0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
         r_fail_exp  <= '0;
      end else begin
         r_chk_valid <= r_en && !r_wen;
         r_chk_addr  <= r_addr;
         r_chk_exp   <= r_exp;
         if (w_miss) begin
            r_fail <= 1'b1;
            if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
            if (!r_fail) begin
               r_fail_addr <= r_chk_addr;
               r_fail_data <= ram_dout;
               r_fail_exp  <= r_chk_exp;
            end
         end
      end
   end

   assign ram_en        = r_en;
   assign ram_wen       = r_wen;
   assign ram_addr      = r_addr;
   assign ram_din       = r_din;
   assign busy          = r_busy;
   assign done          = r_done;
   assign fail          = r_fail;
   assign err_count     = r_err;
   assign fail_addr     = r_fail_addr;
   assign fail_data     = r_fail_data;
   assign fail_expected = r_fail_exp;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: RAM model with injectable stuck-at cell and
// a March C- reference built from element loops.
module tb_ram_march_bist;

   localparam int DW = 8;
   localparam int AW = 2;
   localparam int N  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] background;
   logic          ram_en, ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din, ram_dout;
   logic          busy, done, fail;
   logic [15:0]   err_count;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data, fail_expected;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_march_bist #(.DATA_WIDTH(DW), .BYTE_ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .background(background),
      .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy), .done(done),
      .fail(fail), .err_count(err_count), .fail_addr(fail_addr),
      .fail_data(fail_data), .fail_expected(fail_expected)
   );

   // RAM with an optional stuck-at cell applied on the read path
   logic [DW-1:0] mem [N];
   logic [DW-1:0] r_dout = '0;
   bit            flt_on = 0;
   int            flt_addr = 0;
   logic [DW-1:0] sa0 = '0, sa1 = '0;

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_wen) mem[ram_addr] <= ram_din;
         else if (flt_on && int'(ram_addr) == flt_addr)
            r_dout <= (mem[ram_addr] & ~sa0) | sa1;
         else r_dout <= mem[ram_addr];
      end
   end
   assign ram_dout = r_dout;

   typedef struct {bit wr; int addr; logic [DW-1:0] d;} op_t;
   op_t ops[$];
   int            m_err, m_faddr;
   logic [DW-1:0] m_fdata, m_fexp;

   function automatic void build(input logic [DW-1:0] bg);
      ops.delete();
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            int a;
            a = (e == 3 || e == 4) ? N - 1 - i : i;
            if (e > 0)
               ops.push_back('{0, a, (e == 2 || e == 4) ? ~bg : bg});
            if (e < 5)
               ops.push_back('{1, a, (e == 1 || e == 3) ? ~bg : bg});
         end
      end
   endfunction

   function automatic void model_result();
      logic [DW-1:0] m [N];
      logic [DW-1:0] v;
      m_err = 0; m_faddr = 0; m_fdata = '0; m_fexp = '0;
      foreach (ops[k]) begin
         if (ops[k].wr) m[ops[k].addr] = ops[k].d;
         else begin
            v = m[ops[k].addr];
            if (flt_on && ops[k].addr == flt_addr) v = (v & ~sa0) | sa1;
            if (v !== ops[k].d) begin
               if (m_err == 0) begin
                  m_faddr = ops[k].addr; m_fdata = v; m_fexp = ops[k].d;
               end
               if (m_err < 65535) m_err++;
            end
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic run_test(input logic [DW-1:0] bg, input int restart_at);
      int nw, nr;
      op_t o;
      logic [DW-1:0] d;
      build(bg);
      model_result();
      @(negedge clk); background = bg; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("start_done", 32'(done), 0);
      chk("start_fail", 32'(fail), 0);
      chk("start_err", 32'(err_count), 0);
      chk("start_faddr", 32'(fail_addr), 0);
      chk("start_fdata", 32'(fail_data), 0);
      chk("start_fexp", 32'(fail_expected), 0);
      nw = 0; nr = 0;
      for (int c = 1; c <= 10 * N; c++) begin
         if (c > 1) @(negedge clk);
         if (c == restart_at) begin
            start = 1'b1; background = ~bg;
         end else start = 1'b0;
         o = ops[c-1];
         d = o.wr ? o.d : '0;
         if (ram_en && ram_wen) nw++;
         if (ram_en && !ram_wen) nr++;
         chk($sformatf("op_c%0d", c),
             32'({busy, ram_en, ram_wen, ram_addr, ram_din}),
             32'({1'b1, 1'b1, o.wr, 2'(o.addr), d}));
      end
      @(negedge clk); start = 1'b0;
      chk("flush", 32'({busy, done, ram_en}), 32'(3'b100));
      @(negedge clk);
      chk("end_state", 32'({busy, done, ram_en}), 32'(3'b010));
      chk("end_fail", 32'(fail), 32'(m_err != 0));
      chk("end_err", 32'(err_count), 32'(m_err));
      chk("end_faddr", 32'(fail_addr), 32'(m_faddr));
      chk("end_fdata", 32'(fail_data), 32'(m_fdata));
      chk("end_fexp", 32'(fail_expected), 32'(m_fexp));
      chk("n_writes", 32'(nw), 32'(5 * N));
      chk("n_reads", 32'(nr), 32'(5 * N));
      repeat (2) @(negedge clk);
      chk("done_hold", 32'({done, fail, err_count}),
          32'({1'b1, m_err != 0, 16'(m_err)}));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; background = '0;
      repeat (2) @(negedge clk);
      chk("rst_ram", 32'({ram_en, ram_wen, ram_addr, ram_din}), 0);
      chk("rst_status", 32'({busy, done, fail, err_count}), 0);
      chk("rst_fail_info", 32'({fail_addr, fail_data, fail_expected}), 0);
      rst_n = 1'b1;

      run_test(8'hA5, 0);
      run_test(8'h00, 0);

      flt_on = 1; flt_addr = 2; sa1 = 8'h01; sa0 = 8'h00;
      run_test(8'h00, 0);
      chk("sa1_err3", 32'(err_count), 3);
      chk("sa1_faddr", 32'(fail_addr), 2);
      chk("sa1_fdata", 32'(fail_data), 32'h01);

      flt_on = 0;
      run_test(8'h3C, 0);
      run_test(8'($urandom), 10);

      @(negedge clk); background = 8'h5A; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (16) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst", 32'({ram_en, busy, done, err_count}), 0);
      repeat (2) @(negedge clk);
      chk("midrst_hold", 32'({ram_en, busy, done}), 0);
      rst_n = 1'b1;
      run_test(8'h5A, 0);

      for (int t = 0; t < 6; t++) begin
         int b;
         flt_on = ($urandom_range(0, 2) != 0);
         flt_addr = $urandom_range(0, N - 1);
         b = $urandom_range(0, DW - 1);
         if ($urandom_range(0, 1) == 1) begin
            sa1 = 8'(1 << b); sa0 = '0;
         end else begin
            sa0 = 8'(1 << b); sa1 = '0;
         end
         run_test(8'($urandom), (t == 3) ? $urandom_range(1, 10 * N) : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
March C- built-in self-test initiator for the single-port sequential RAM array. It drives the RAM's en/wen/addr/din port and checks its registered dout, with one-cycle read latency. Software or the random test generator pulses start with a data background. The block reports pass/fail, the first failing location and a saturating error count.

Parameters:
DATA_WIDTH, 32, RAM word width; width of ram_din, ram_dout, background and fail data.
BYTE_ADDR_WIDTH, 8, RAM address width; N = 2**BYTE_ADDR_WIDTH words tested.

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin test; sampled only when busy=0.
background  in  DATA_WIDTH  pattern "0"; its bitwise inverse is pattern "1"; captured at start.
ram_en  out  1  RAM enable, registered.
ram_wen  out  1  RAM write enable, registered.
ram_addr  out  BYTE_ADDR_WIDTH  RAM address, registered.
ram_din  out  DATA_WIDTH  RAM write data, registered.
ram_dout  in  DATA_WIDTH  RAM read data, valid the cycle after a read is issued.
busy  out  1  test in progress.
done  out  1  test finished; held until the next start.
fail  out  1  sticky; at least one miscompare in the current or last test.
err_count  out  16  miscompare count, saturates at 16'hFFFF.
fail_addr  out  BYTE_ADDR_WIDTH  address of the first miscompare.
fail_data  out  DATA_WIDTH  ram_dout value at the first miscompare.
fail_expected  out  DATA_WIDTH  expected value at the first miscompare.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=IDLE, check pipeline cleared. Reset mid-test aborts immediately; ram_en=0 while rst_n=0.
- FSM states: IDLE -> M0..M5 -> DONE -> (start) -> M0. In IDLE/DONE: ram_en=0, busy=0.
- start=1 at edge E0 while busy=0:
  - latch background;
  - clear done, fail, err_count and fail_* registers;
  - busy=1;
  - first op is driven in the cycle after E0.
- start while busy=1 is ignored.
- March elements (B=background, ~B=inverse); exactly one RAM op per cycle, no idle cycles:
  - M0 ascending: w B.
  - M1 ascending: r B, w ~B.
  - M2 ascending: r ~B, w B.
  - M3 descending: r B, w ~B.
  - M4 descending: r ~B, w B.
  - M5 ascending: r B.
- In M1..M4, each address gets a read then a write on consecutive cycles, then the address steps.
- Ascending order is 0..N-1; descending order is N-1..0. The address counter must not wrap between elements. M3 starts at N-1.
- Total ops: 10N (5N reads, 5N writes).
- Read op: ram_en=1, ram_wen=0, ram_din=0.
- Write op: ram_en=1, ram_wen=1.
- Check pipeline:
  - A read issued in cycle k loads chk_valid, chk_addr and chk_exp for cycle k+1.
  - In cycle k+1, ram_dout is compared with chk_exp when chk_valid=1.
  - On a miscompare: err_count increments (saturating) and fail=1.
  - If fail was 0 before the miscompare, fail_addr, fail_data and fail_expected are captured.
- Termination:
  - The last op (M5 read of N-1) is in cycle 10N; its compare is in cycle 10N+1.
  - At edge E(10N+1): busy=0, done=1, state=DONE.
  - The test never aborts on failure.
- DONE holds all results stable until the next start or reset.

Test Plan:
- Bench setup: DATA_WIDTH=8, BYTE_ADDR_WIDTH=2 (N=4), connected to the sequential RAM model.
- Fault-free, background=8'hA5, start at E0 -> busy 1 for E0..E40; done=1 at E41; fail=0, err_count=0; exactly 20 writes and 20 reads seen on ram_*.
- Address order, background=8'h00 -> M3/M4 addresses 3,2,1,0; M5 ends at addr 3; write data ~B=8'hFF in M1 and M3.
- Stuck-at-1 on bit0 of addr 2 (bench wrapper forces ram_dout[0]=1 for addr 2), background=8'h00 -> fail=1, err_count=3 (M1, M3, M5 reads); fail_addr=2, fail_data=8'h01, fail_expected=8'h00.
- Restart after the failing run with a fault-free RAM, background=8'h3C -> start clears fail/err_count/fail_*; done re-asserts at E41 with fail=0.
- start pulsed again at cycle 10 of a run -> ignored; done still at E41; op count unchanged.
- rst_n low at cycle 17 for 2 cycles -> ram_en=0, busy=0, done=0, err_count=0 immediately; the next start runs a full 10N test.
